// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset release sequencer.
// Contents:
//   seq_state_e - sequencer state encoding (HOLD, RELEASE, WAIT, RUN), 2 bits
//   idx_width() - width of a domain index for a given domain count
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RUN     = 2'd3
    } seq_state_e;

    // Index width; at least one bit even for a single domain
    function automatic int idx_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Up-counter shared by the HOLD and WAIT phases of the reset sequencer.
// Ports:
//   clk    - system clock
//   rst    - synchronous active-low reset (counter to 0)
//   clr    - synchronous clear, takes priority over inc
//   inc    - count enable
//   target - terminal count value
//   tc     - high while the count equals target
// The counter saturates at all-ones instead of wrapping.
module rst_seq_timer #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 inc,
    input  logic [CNT_WIDTH-1:0] target,
    output logic                 tc
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Next count: clear, saturating increment, or hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {CNT_WIDTH{1'b0}};
        end else if (inc && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == target);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset release sequencer. After the system reset (or a software request)
// all domain resets are held for HOLD_CYCLES cycles, then released one per
// index in order, with DELAY_CFG extra cycles after each enabled domain.
// Ports:
//   CLK        - system clock
//   RST        - synchronous active-low reset
//   SW_RST_REQ - one-cycle pulse: re-run the whole sequence
//   DELAY_CFG  - extra cycles between consecutive releases
//   DOMAIN_EN  - per-domain enable; disabled domains stay in reset
//   DOMAIN_RST - per-domain active-low reset (registered)
//   SEQ_BUSY   - sequence in progress (registered)
//   SEQ_DONE   - one-cycle completion pulse (registered)
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = 4,
    parameter int CNT_WIDTH   = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   SW_RST_REQ,
    input  logic [CNT_WIDTH-1:0]   DELAY_CFG,
    input  logic [NUM_DOMAINS-1:0] DOMAIN_EN,
    output logic [NUM_DOMAINS-1:0] DOMAIN_RST,
    output logic                   SEQ_BUSY,
    output logic                   SEQ_DONE
);

    localparam int                   IDX_W    = idx_width(NUM_DOMAINS);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_TC  = CNT_WIDTH'(HOLD_CYCLES - 1);

    seq_state_e             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_WIDTH-1:0]   delay_q, delay_d;
    logic [NUM_DOMAINS-1:0] domain_rst_q, domain_rst_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   tmr_clr;
    logic                   tmr_inc;
    logic [CNT_WIDTH-1:0]   tmr_target;
    logic                   tmr_tc;

    rst_seq_timer #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_timer (
        .clk    (CLK),
        .rst    (RST),
        .clr    (tmr_clr),
        .inc    (tmr_inc),
        .target (tmr_target),
        .tc     (tmr_tc)
    );

    // Next-state and output logic; a software request overrides everything
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        delay_d      = delay_q;
        domain_rst_d = domain_rst_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        tmr_clr      = 1'b0;
        tmr_inc      = 1'b0;
        tmr_target   = HOLD_TC;

        if (SW_RST_REQ) begin
            state_d      = ST_HOLD;
            idx_d        = {IDX_W{1'b0}};
            domain_rst_d = {NUM_DOMAINS{1'b0}};
            busy_d       = 1'b1;
            tmr_clr      = 1'b1;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    tmr_target = HOLD_TC;
                    tmr_inc    = 1'b1;
                    if (tmr_tc) begin
                        state_d = ST_RELEASE;
                        idx_d   = {IDX_W{1'b0}};
                        tmr_clr = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_RELEASE: begin
                    if (DOMAIN_EN[idx_q]) begin
                        domain_rst_d[idx_q] = 1'b1;
                    end else begin
                        domain_rst_d[idx_q] = 1'b0;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_RUN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (!DOMAIN_EN[idx_q] || (DELAY_CFG == {CNT_WIDTH{1'b0}})) begin
                        // Disabled domains and zero gaps cost a single cycle
                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        // Gap is frozen here so later DELAY_CFG edits do not stretch it
                        delay_d = DELAY_CFG;
                        tmr_clr = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    tmr_target = delay_q - CNT_WIDTH'(1);
                    tmr_inc    = 1'b1;
                    if (tmr_tc) begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_RELEASE;
                        tmr_clr = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d      = ST_HOLD;
                    idx_d        = {IDX_W{1'b0}};
                    domain_rst_d = {NUM_DOMAINS{1'b0}};
                    busy_d       = 1'b1;
                    tmr_clr      = 1'b1;
                end
            endcase
        end
    end

    // Sequencer registers; RST returns everything to the start of HOLD
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q      <= ST_HOLD;
            idx_q        <= {IDX_W{1'b0}};
            delay_q      <= {CNT_WIDTH{1'b0}};
            domain_rst_q <= {NUM_DOMAINS{1'b0}};
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            delay_q      <= delay_d;
            domain_rst_q <= domain_rst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign DOMAIN_RST = domain_rst_q;
    assign SEQ_BUSY   = busy_q;
    assign SEQ_DONE   = done_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed self-checking bench for rst_seq_ctrl (4 domains, 8-bit counter,
// hold of 4 cycles). Edge k is the k-th rising edge after the reset or
// software-request edge; outputs are sampled 1 time unit after each edge.
// Per-edge expectation is packed as {DOMAIN_RST, SEQ_BUSY, SEQ_DONE}.
module tb_rst_seq_ctrl;

    logic       CLK;
    logic       RST;
    logic       SW_RST_REQ;
    logic [7:0] DELAY_CFG;
    logic [3:0] DOMAIN_EN;
    logic [3:0] DOMAIN_RST;
    logic       SEQ_BUSY;
    logic       SEQ_DONE;

    int errors = 0;
    int checks = 0;

    rst_seq_ctrl #(
        .NUM_DOMAINS (4),
        .CNT_WIDTH   (8),
        .HOLD_CYCLES (4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .SW_RST_REQ (SW_RST_REQ),
        .DELAY_CFG  (DELAY_CFG),
        .DOMAIN_EN  (DOMAIN_EN),
        .DOMAIN_RST (DOMAIN_RST),
        .SEQ_BUSY   (SEQ_BUSY),
        .SEQ_DONE   (SEQ_DONE)
    );

    // Free-running clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Expected {rst[3:0], busy, done} at edge k given hand-computed rise edges
    // (0 = never rises) and the completion edge d.
    function automatic logic [5:0] expv(int k, int r0, int r1, int r2, int r3, int d);
        logic [3:0] r;
        r[0] = (r0 != 0) && (k >= r0);
        r[1] = (r1 != 0) && (k >= r1);
        r[2] = (r2 != 0) && (k >= r2);
        r[3] = (r3 != 0) && (k >= r3);
        return {r, (k < d), (k == d)};
    endfunction

    task automatic apply_reset();
        RST = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b0; SW_RST_REQ = 1'b1; DELAY_CFG = 8'd2; DOMAIN_EN = 4'b1111;
        for (int k = 1; k <= 3; k++) begin
            @(posedge CLK); #1;
            checks++;
            if ({DOMAIN_RST, SEQ_BUSY, SEQ_DONE} !== 6'b0000_1_0) begin
                errors++;
                $display("FAIL reset edge %0d: got %b want %b", k, {DOMAIN_RST, SEQ_BUSY, SEQ_DONE}, 6'b0000_1_0);
            end
        end
        SW_RST_REQ = 1'b0;
        RST = 1'b1;
    endtask

    task automatic test_normal();
        logic [5:0] e;
        DELAY_CFG = 8'd2; DOMAIN_EN = 4'b1111;
        apply_reset();
        for (int k = 1; k <= 16; k++) begin
            @(posedge CLK); #1;
            e = expv(k, 5, 8, 11, 14, 14);
            checks++;
            if ({DOMAIN_RST, SEQ_BUSY, SEQ_DONE} !== e) begin
                errors++;
                $display("FAIL normal edge %0d: got %b want %b", k, {DOMAIN_RST, SEQ_BUSY, SEQ_DONE}, e);
            end
        end
    endtask

    task automatic test_zero_delay();
        logic [5:0] e;
        DELAY_CFG = 8'd0; DOMAIN_EN = 4'b1111;
        apply_reset();
        for (int k = 1; k <= 10; k++) begin
            @(posedge CLK); #1;
            e = expv(k, 5, 6, 7, 8, 8);
            checks++;
            if ({DOMAIN_RST, SEQ_BUSY, SEQ_DONE} !== e) begin
                errors++;
                $display("FAIL zero_delay edge %0d: got %b want %b", k, {DOMAIN_RST, SEQ_BUSY, SEQ_DONE}, e);
            end
        end
    endtask

    // idx0 skipped (edge 5), bit1 at 6, gap 7..9, idx2 skipped (10), bit3 at 11
    task automatic test_disabled();
        logic [5:0] e;
        DELAY_CFG = 8'd3; DOMAIN_EN = 4'b1010;
        apply_reset();
        for (int k = 1; k <= 13; k++) begin
            @(posedge CLK); #1;
            e = expv(k, 0, 6, 0, 11, 11);
            checks++;
            if ({DOMAIN_RST, SEQ_BUSY, SEQ_DONE} !== e) begin
                errors++;
                $display("FAIL disabled edge %0d: got %b want %b", k, {DOMAIN_RST, SEQ_BUSY, SEQ_DONE}, e);
            end
        end
    endtask

    task automatic test_all_disabled();
        logic [5:0] e;
        DELAY_CFG = 8'd5; DOMAIN_EN = 4'b0000;
        apply_reset();
        for (int k = 1; k <= 10; k++) begin
            @(posedge CLK); #1;
            e = expv(k, 0, 0, 0, 0, 8);
            checks++;
            if ({DOMAIN_RST, SEQ_BUSY, SEQ_DONE} !== e) begin
                errors++;
                $display("FAIL all_disabled edge %0d: got %b want %b", k, {DOMAIN_RST, SEQ_BUSY, SEQ_DONE}, e);
            end
        end
    endtask

    task automatic test_sw_rst_run();
        logic [5:0] e;
        DELAY_CFG = 8'd2; DOMAIN_EN = 4'b1111;
        apply_reset();
        repeat (16) @(posedge CLK);
        #1;
        // In RUN, enable changes must not touch the released resets
        DOMAIN_EN = 4'b0001;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({DOMAIN_RST, SEQ_BUSY, SEQ_DONE} !== 6'b1111_0_0) begin
            errors++;
            $display("FAIL run_hold: got %b want %b", {DOMAIN_RST, SEQ_BUSY, SEQ_DONE}, 6'b1111_0_0);
        end
        DOMAIN_EN = 4'b1111;
        SW_RST_REQ = 1'b1;
        @(posedge CLK); #1;
        SW_RST_REQ = 1'b0;
        checks++;
        if ({DOMAIN_RST, SEQ_BUSY, SEQ_DONE} !== 6'b0000_1_0) begin
            errors++;
            $display("FAIL sw_run_req: got %b want %b", {DOMAIN_RST, SEQ_BUSY, SEQ_DONE}, 6'b0000_1_0);
        end
        for (int k = 1; k <= 15; k++) begin
            @(posedge CLK); #1;
            e = expv(k, 5, 8, 11, 14, 14);
            checks++;
            if ({DOMAIN_RST, SEQ_BUSY, SEQ_DONE} !== e) begin
                errors++;
                $display("FAIL sw_run_seq edge %0d: got %b want %b", k, {DOMAIN_RST, SEQ_BUSY, SEQ_DONE}, e);
            end
        end
    endtask

    task automatic test_sw_rst_wait();
        logic [5:0] e;
        DELAY_CFG = 8'd2; DOMAIN_EN = 4'b1111;
        apply_reset();
        repeat (8) @(posedge CLK);
        #1;
        // bit1 released at edge 8; request lands in WAIT
        SW_RST_REQ = 1'b1;
        @(posedge CLK); #1;
        SW_RST_REQ = 1'b0;
        checks++;
        if ({DOMAIN_RST, SEQ_BUSY, SEQ_DONE} !== 6'b0000_1_0) begin
            errors++;
            $display("FAIL sw_wait_req: got %b want %b", {DOMAIN_RST, SEQ_BUSY, SEQ_DONE}, 6'b0000_1_0);
        end
        for (int k = 1; k <= 15; k++) begin
            @(posedge CLK); #1;
            e = expv(k, 5, 8, 11, 14, 14);
            checks++;
            if ({DOMAIN_RST, SEQ_BUSY, SEQ_DONE} !== e) begin
                errors++;
                $display("FAIL sw_wait_seq edge %0d: got %b want %b", k, {DOMAIN_RST, SEQ_BUSY, SEQ_DONE}, e);
            end
        end
    endtask

    task automatic test_sw_rst_final();
        logic [5:0] e;
        DELAY_CFG = 8'd0; DOMAIN_EN = 4'b1111;
        apply_reset();
        repeat (7) @(posedge CLK);
        #1;
        // Edge 8 would process the last index; the request must win
        SW_RST_REQ = 1'b1;
        @(posedge CLK); #1;
        SW_RST_REQ = 1'b0;
        checks++;
        if ({DOMAIN_RST, SEQ_BUSY, SEQ_DONE} !== 6'b0000_1_0) begin
            errors++;
            $display("FAIL sw_final_req: got %b want %b", {DOMAIN_RST, SEQ_BUSY, SEQ_DONE}, 6'b0000_1_0);
        end
        for (int k = 1; k <= 9; k++) begin
            @(posedge CLK); #1;
            e = expv(k, 5, 6, 7, 8, 8);
            checks++;
            if ({DOMAIN_RST, SEQ_BUSY, SEQ_DONE} !== e) begin
                errors++;
                $display("FAIL sw_final_seq edge %0d: got %b want %b", k, {DOMAIN_RST, SEQ_BUSY, SEQ_DONE}, e);
            end
        end
    endtask

    task automatic test_rst_mid();
        logic [5:0] e;
        DELAY_CFG = 8'd0; DOMAIN_EN = 4'b1111;
        apply_reset();
        repeat (6) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        checks++;
        if ({DOMAIN_RST, SEQ_BUSY, SEQ_DONE} !== 6'b0000_1_0) begin
            errors++;
            $display("FAIL rst_mid: got %b want %b", {DOMAIN_RST, SEQ_BUSY, SEQ_DONE}, 6'b0000_1_0);
        end
        for (int k = 1; k <= 9; k++) begin
            @(posedge CLK); #1;
            e = expv(k, 5, 6, 7, 8, 8);
            checks++;
            if ({DOMAIN_RST, SEQ_BUSY, SEQ_DONE} !== e) begin
                errors++;
                $display("FAIL rst_mid_seq edge %0d: got %b want %b", k, {DOMAIN_RST, SEQ_BUSY, SEQ_DONE}, e);
            end
        end
    endtask

    // Gap 2 latched at edge 5; DELAY_CFG=7 then applies from the idx1 release
    task automatic test_latched_delay();
        logic [5:0] e;
        DELAY_CFG = 8'd2; DOMAIN_EN = 4'b1111;
        apply_reset();
        for (int k = 1; k <= 26; k++) begin
            @(posedge CLK); #1;
            if (k == 5) begin
                DELAY_CFG = 8'd7;
            end else begin
                DELAY_CFG = DELAY_CFG;
            end
            e = expv(k, 5, 8, 16, 24, 24);
            checks++;
            if ({DOMAIN_RST, SEQ_BUSY, SEQ_DONE} !== e) begin
                errors++;
                $display("FAIL latched_delay edge %0d: got %b want %b", k, {DOMAIN_RST, SEQ_BUSY, SEQ_DONE}, e);
            end
        end
    endtask

    initial begin
        RST = 1'b0; SW_RST_REQ = 1'b0; DELAY_CFG = 8'd0; DOMAIN_EN = 4'b0000;
        test_reset();
        test_normal();
        test_zero_delay();
        test_disabled();
        test_all_disabled();
        test_sw_rst_run();
        test_sw_rst_wait();
        test_sw_rst_final();
        test_rst_mid();
        test_latched_delay();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
